// File: rtl/btb_lru.sv
// btb_lru: fully associative branch target buffer with true-LRU replacement.
// Optional feature macro: BTB_COUNTER_EN enables 2-bit saturating direction counters;
// without it, predict_taken follows hit and a not-taken update invalidates its entry.
module btb_lru #(
    parameter int ENTRIES = 4,
    parameter int W_PC    = 8,
    parameter int W_BTA   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [W_PC-1:0]  pc,
    output logic             hit,
    output logic [W_BTA-1:0] bta,
    output logic             predict_taken,
    input  logic             upd_valid,
    input  logic [W_PC-1:0]  upd_pc,
    input  logic [W_BTA-1:0] upd_target,
    input  logic             upd_taken
);
    localparam int AW = $clog2(ENTRIES);
    localparam logic [AW-1:0] AGE_MAX = AW'(ENTRIES - 1);

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [W_PC-1:0]  tag_q    [ENTRIES];
    logic [W_PC-1:0]  tag_d    [ENTRIES];
    logic [W_BTA-1:0] target_q [ENTRIES];
    logic [W_BTA-1:0] target_d [ENTRIES];
    logic [AW-1:0]    age_q    [ENTRIES];
    logic [AW-1:0]    age_d    [ENTRIES];
`ifdef BTB_COUNTER_EN
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
`endif

    logic          upd_hit;
    logic [AW-1:0] upd_idx;
    logic          inv_found;
    logic [AW-1:0] inv_idx;
    logic [AW-1:0] lru_idx;
    logic [AW-1:0] vic_idx;
    logic          touch;
    logic [AW-1:0] touch_idx;

    // Fetch lookup: purely combinational, tags are unique so at most one entry matches
    always_comb begin
        hit           = 1'b0;
        bta           = '0;
        predict_taken = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == pc) begin
                hit = 1'b1;
                bta = target_q[i];
`ifdef BTB_COUNTER_EN
                predict_taken = ctr_q[i][1];
`else
                predict_taken = 1'b1;
`endif
            end
        end
    end

    // Update-port match and victim choice: lowest invalid entry first, else the LRU entry
    always_comb begin
        upd_hit   = 1'b0;
        upd_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        lru_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == upd_pc) begin
                upd_hit = 1'b1;
                upd_idx = AW'(i);
            end
            if (age_q[i] == AGE_MAX) lru_idx = AW'(i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = AW'(i);
            end
        end
        vic_idx = inv_found ? inv_idx : lru_idx;
    end

    // Next state: flush beats update; hit refreshes, taken miss allocates, touch reorders ages
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        age_d     = age_q;
`ifdef BTB_COUNTER_EN
        ctr_d     = ctr_q;
`endif
        touch     = 1'b0;
        touch_idx = '0;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
        end else if (upd_valid) begin
            if (upd_hit) begin
`ifdef BTB_COUNTER_EN
                ctr_d[upd_idx] = upd_taken
                    ? ((ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01)
                    : ((ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01);
                if (upd_taken) target_d[upd_idx] = upd_target;
                touch     = 1'b1;
                touch_idx = upd_idx;
`else
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    touch             = 1'b1;
                    touch_idx         = upd_idx;
                end else begin
                    valid_d[upd_idx] = 1'b0;
                end
`endif
            end else if (upd_taken) begin
                valid_d[vic_idx]  = 1'b1;
                tag_d[vic_idx]    = upd_pc;
                target_d[vic_idx] = upd_target;
`ifdef BTB_COUNTER_EN
                ctr_d[vic_idx]    = 2'b10;
`endif
                touch     = 1'b1;
                touch_idx = vic_idx;
            end
        end
        if (touch) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (age_q[j] < age_q[touch_idx]) age_d[j] = age_q[j] + AW'(1);
            end
            age_d[touch_idx] = '0;
        end
    end

    // State registers; ages reset to the index order so they start as a permutation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                age_q[i]    <= AW'(i);
`ifdef BTB_COUNTER_EN
                ctr_q[i]    <= 2'b00;
`endif
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            age_q    <= age_d;
`ifdef BTB_COUNTER_EN
            ctr_q    <= ctr_d;
`endif
        end
    end
endmodule

// File: tb/tb_btb_lru.sv
// tb_btb_lru: table-driven bench for btb_lru (default 4 entries); BTB_COUNTER_EN selects the counter sequence
module tb_btb_lru;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  pc = '0;
    logic        hit;
    logic [31:0] bta;
    logic        predict_taken;
    logic        upd_valid = 1'b0;
    logic [7:0]  upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        uv;
        logic [7:0]  upc;
        logic [31:0] utgt;
        logic        utk;
        logic        fl;
        logic [7:0]  lpc;
        logic        ehit;
        logic [31:0] ebta;
        logic        epred;
    } vec_t;

    vec_t q[$];

    btb_lru #(.ENTRIES(4), .W_PC(8), .W_BTA(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .pc(pc),
        .hit(hit), .bta(bta), .predict_taken(predict_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic uv, input logic [7:0] upc, input logic [31:0] utgt, input logic utk,
                       input logic fl, input logic [7:0] lpc, input logic ehit, input logic [31:0] ebta,
                       input logic epred);
        vec_t v;
        v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk; v.fl = fl;
        v.lpc = lpc; v.ehit = ehit; v.ebta = ebta; v.epred = epred;
        q.push_back(v);
    endtask

    task automatic run_table(input string tname);
        foreach (q[k]) begin
            @(negedge clk);
            upd_valid = q[k].uv; upd_pc = q[k].upc; upd_target = q[k].utgt;
            upd_taken = q[k].utk; flush = q[k].fl; pc = q[k].lpc;
            #1;
            chk($sformatf("%s[%0d] hit pc=%h", tname, k, q[k].lpc), 32'(hit), 32'(q[k].ehit));
            chk($sformatf("%s[%0d] bta pc=%h", tname, k, q[k].lpc), bta, q[k].ebta);
            chk($sformatf("%s[%0d] pred pc=%h", tname, k, q[k].lpc), 32'(predict_taken), 32'(q[k].epred));
        end
        @(negedge clk);
        upd_valid = 1'b0; flush = 1'b0;
        q.delete();
    endtask

    task automatic async_reset(input logic [7:0] p, input logic [31:0] pre_bta);
        @(negedge clk);
        upd_valid = 1'b0; flush = 1'b0; pc = p;
        #1;
        chk("pre-reset hit", 32'(hit), 32'd1);
        chk("pre-reset bta", bta, pre_bta);
        #1 reset = 1'b0;
        #1;
        chk("async reset hit", 32'(hit), 32'd0);
        chk("async reset bta", bta, 32'd0);
        chk("async reset pred", 32'(predict_taken), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #12 reset = 1'b1;

        add(0, 8'h00, 32'h0, 0, 0, 8'h08, 0, 32'h0, 0);
        add(1, 8'h08, 32'h1000, 1, 0, 8'h08, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h08, 1, 32'h1000, 1);
        run_table("first");
        async_reset(8'h08, 32'h1000);

        add(1, 8'h10, 32'h100, 1, 0, 8'h10, 0, 32'h0, 0);
        add(1, 8'h20, 32'h200, 1, 0, 8'h10, 1, 32'h100, 1);
        add(1, 8'h30, 32'h300, 1, 0, 8'h20, 1, 32'h200, 1);
        add(1, 8'h40, 32'h400, 1, 0, 8'h30, 1, 32'h300, 1);
        add(1, 8'h10, 32'h111, 1, 0, 8'h40, 1, 32'h400, 1);
        add(1, 8'h50, 32'h500, 1, 0, 8'h10, 1, 32'h111, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h20, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h10, 1, 32'h111, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h30, 1, 32'h300, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h40, 1, 32'h400, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h50, 1, 32'h500, 1);
        add(1, 8'h66, 32'h660, 1, 0, 8'h66, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h66, 1, 32'h660, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h30, 0, 32'h0, 0);
        add(1, 8'h70, 32'h700, 1, 1, 8'h10, 1, 32'h111, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h70, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h10, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h66, 0, 32'h0, 0);
        add(1, 8'h71, 32'h710, 1, 0, 8'h71, 0, 32'h0, 0);
        add(1, 8'h72, 32'h720, 1, 0, 8'h71, 1, 32'h710, 1);
        add(1, 8'h73, 32'h730, 1, 0, 8'h72, 1, 32'h720, 1);
        add(1, 8'h74, 32'h740, 1, 0, 8'h73, 1, 32'h730, 1);
        add(1, 8'h75, 32'h750, 1, 0, 8'h74, 1, 32'h740, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h71, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h72, 1, 32'h720, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h75, 1, 32'h750, 1);
        run_table("lru");
        async_reset(8'h74, 32'h740);

`ifdef BTB_COUNTER_EN
        add(1, 8'h24, 32'hA0, 1, 0, 8'h24, 0, 32'h0, 0);
        add(1, 8'h24, 32'hB0, 0, 0, 8'h24, 1, 32'hA0, 1);
        add(1, 8'h24, 32'hB0, 0, 0, 8'h24, 1, 32'hA0, 0);
        add(1, 8'h24, 32'hB0, 1, 0, 8'h24, 1, 32'hA0, 0);
        add(1, 8'h24, 32'hC0, 1, 0, 8'h24, 1, 32'hB0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h24, 1, 32'hC0, 1);
        for (int n = 0; n < 5; n++) add(1, 8'h24, 32'hC0, 1, 0, 8'h24, 1, 32'hC0, 1);
        add(1, 8'h24, 32'hD0, 0, 0, 8'h24, 1, 32'hC0, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h24, 1, 32'hC0, 1);
`else
        add(1, 8'h24, 32'hA0, 1, 0, 8'h24, 0, 32'h0, 0);
        add(1, 8'h24, 32'hB0, 1, 0, 8'h24, 1, 32'hA0, 1);
        add(1, 8'h24, 32'hC0, 0, 0, 8'h24, 1, 32'hB0, 1);
        add(0, 8'h00, 32'h0, 0, 0, 8'h24, 0, 32'h0, 0);
`endif
        add(1, 8'h99, 32'h990, 0, 0, 8'h99, 0, 32'h0, 0);
        add(0, 8'h00, 32'h0, 0, 0, 8'h99, 0, 32'h0, 0);
        run_table("dir");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/btb_lru.md
# btb_lru

Parametrised branch target buffer for the fetch stage: fully associative, ENTRIES deep, true-LRU replacement, optional 2-bit direction counters. Fetch looks it up combinationally each cycle with the low PC bits. The execute stage writes resolved branches back into it through a registered update port. It is the fixed 3-entry buffer generalised in depth and tag width, with valid bits, flush, and direction prediction.

## Interface
- ENTRIES, 4, number of entries; integer ≥ 2; age field width AW = $clog2(ENTRIES)
- W_PC, 8, tag width; low W_PC bits of the branch PC
- W_BTA, 32, branch target address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately while low
- flush  in  1  synchronous; invalidates every entry on the next edge
- pc  in  W_PC  fetch lookup tag
- hit  out  1  lookup matched a valid entry
- bta  out  W_BTA  predicted target; 0 when hit=0
- predict_taken  out  1  fetch should redirect to bta
- upd_valid  in  1  execute-stage resolved branch this cycle
- upd_pc  in  W_PC  tag of resolved branch
- upd_target  in  W_BTA  computed target of resolved branch
- upd_taken  in  1  branch was actually taken

## Operation
- Per entry: valid, tag[W_PC], target[W_BTA], ctr[2], age[AW]. Age 0 = MRU, ENTRIES-1 = LRU; ages always form a permutation of 0..ENTRIES-1.
- Lookup is purely combinational: hit = OR over entries (valid && tag==pc). bta = target of the matching entry. Tags are unique by construction, so at most one entry matches.
- predict_taken = hit && ctr[1]. Lookup never changes recency or counters.
- Update when upd_valid=1, upd hit (valid entry with tag==upd_pc):
  - ctr saturates toward 3 if taken, toward 0 if not taken.
  - target ← upd_target if taken.
  - entry touched.
- Update when upd_valid=1, upd miss, upd_taken=1: allocate.
  - Victim is the lowest-index invalid entry; if none, the entry with age ENTRIES-1.
  - Write valid=1, tag=upd_pc, target=upd_target, ctr=2'b10; entry touched.
- Update when upd_valid=1, upd miss, upd_taken=0: no state change.
- Touch entry i: every entry with age < age_i increments; entry i's age ← 0; all others unchanged.
- flush=1: all valid ← 0; ages, tags, targets, counters keep their values. flush has priority over a same-cycle update, which is dropped.
- Reset values (reset low):
  - all valid=0, tag=0, target=0, ctr=0
  - age of entry i = i
  - outputs: hit=0, bta=0, predict_taken=0

## Timing
- Lookup latency: 0 cycles, from pc to hit/bta/predict_taken.
- Update latency: 1 cycle. An update sampled at edge N is visible to lookups after edge N.
- No bypass: a lookup of upd_pc in the same cycle as its update returns the pre-update contents.
- One update per cycle; no handshake or backpressure. upd_valid is a single-cycle qualifier.
- Reset asserted mid-operation clears state asynchronously, regardless of clk. The first update is accepted on the first edge after reset deasserts.
- Counter arithmetic is 2-bit saturating: 3+taken=3, 0+not-taken=0. Ages never exceed ENTRIES-1.

## Configuration
- BTB_COUNTER_EN defined: ctr fields implemented; predict_taken = hit && ctr[1]; behaviour as above.
- BTB_COUNTER_EN undefined:
  - no ctr storage; predict_taken = hit.
  - update hit with upd_taken=0 invalidates that entry (valid ← 0, ages unchanged); with upd_taken=1, target refreshed and entry touched.
  - allocation rules unchanged.

## Test plan
- Reset then lookup pc=0x08 -> hit=0, bta=0, predict_taken=0. Update pc=0x08, target=0x1000, taken=1; next cycle lookup 0x08 -> hit=1, bta=0x1000, predict_taken=1 (ctr=2).
- ENTRIES=4: allocate taken branches with tags 0x10, 0x20, 0x30, 0x40; update 0x10 taken again; allocate 0x50 -> 0x20 evicted (miss), and 0x10, 0x30, 0x40, 0x50 all hit.
- With BTB_COUNTER_EN: tag 0x24 allocated, then two not-taken updates -> predict_taken=0 while hit=1 (ctr=0). Two taken updates -> predict_taken=1. Five taken updates keep ctr=3; one not-taken then gives predict_taken=1.
- Same-cycle update and lookup of new tag 0x66 -> hit=0 that cycle, hit=1 the next.
- flush together with upd_valid for tag 0x70 -> all lookups miss afterwards, including 0x70. Subsequent allocation fills entry 0 first.
- Assert reset asynchronously between clock edges with 4 valid entries -> hit falls to 0 before the next edge. After release, ages are 0..3 by index.
